knight_rider_seq: RTL and testbench
===================================

# knight_rider_seq

Parametrised Knight Rider LED sequencer for the Zedboard user LEDs. It moves a lit "head" across `N_LEDS` outputs at a runtime-programmable step rate, with three motion modes. A decaying trail of up to `TRAIL` previous positions is rendered through per-LED PWM. It sits directly between the board clock/reset and the LED pins, replacing the fixed 8-LED single-speed bounce.

## Interface
- `N_LEDS`, 8: number of LED outputs, ≥2.
- `PRESC_W`, 32: width of the step-period prescaler and of `period`.
- `PWM_W`, 4: PWM counter width; full brightness = 2^PWM_W−1.
- `TRAIL`, 3: number of trailing positions rendered, 0..PWM_W−1.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset rst, asynchronous, active-high.
- `en`, in, 1: run enable; low freezes motion, LEDs keep displaying.
- `mode`, in, 2: 0 bounce, 1 wrap-left, 2 wrap-right, 3 reserved (behaves as bounce).
- `period`, in, PRESC_W: clocks per step; 0 treated as 1.
- `leds`, out, N_LEDS: registered PWM LED drive.
- `pos`, out, clog2(N_LEDS): current head index.
- `dir`, out, 1: 1 = moving left (increasing index), 0 = right.
- `step`, out, 1: one-cycle pulse on the cycle `pos` updates.

## Operation
- FSM states: IDLE, RUN, HOLD.
  - Reset enters IDLE.
  - IDLE→RUN when `en`=1.
  - RUN→HOLD when `en`=0.
  - HOLD→RUN when `en`=1.
  - IDLE is only re-entered by reset.
- Reset values: `leds`=0, `pos`=0, `dir`=1, `step`=0, prescaler=0, PWM counter=0, all history entries invalid.
- In IDLE `leds` is forced to 0. In RUN and HOLD the pattern is displayed.
- Prescaler counts only in RUN. When prescaler ≥ max(period,1)−1, it asserts `step` and clears to 0 in that cycle.
  - Lowering `period` below the current count therefore steps on the next RUN cycle.
- HOLD keeps the prescaler value, so the remaining interval resumes after re-enable.
- On step, the old `pos` is pushed into the history shift register (entry 0 = newest, marked valid) and the oldest entry is dropped.
- Motion, with `mode` sampled on the step cycle:
  - Bounce, `dir`=1: if `pos`=N−1, set `dir`=0 and `pos`=N−2. Otherwise `pos`+1.
  - Bounce, `dir`=0: if `pos`=0, set `dir`=1 and `pos`=1. Otherwise `pos`−1.
  - Bounce has no dwell at the ends; one full sweep is 2(N−1) steps.
  - Wrap-left: `pos`=(`pos`+1) mod N, `dir`=1.
  - Wrap-right: `pos`=(`pos`−1) mod N, `dir`=0. Index 0 goes to N−1.
  - Switching from a wrap mode back to bounce continues from the current `pos`/`dir`.
- Brightness per LED i is the maximum over:
  - 2^PWM_W−1 if i=`pos`.
  - (2^PWM_W−1)>>(k+1) for each valid history entry k<TRAIL equal to i.
  - Otherwise 0.
  - On a bounce reversal the head therefore overrides its own trail.
- PWM: a free-running PWM_W-bit counter wraps 2^PWM_W−1→0. `leds[i]` is 1 when counter < duty(i).
  - Duty 2^PWM_W−1 is on for 2^PWM_W−1 of every 2^PWM_W cycles; duty 0 is never on.
- Async reset mid-sweep clears everything immediately; there is no partial step.

## Timing
- `step` is high in the same cycle that `pos`/`dir`/history take their new values (registered outputs update at the edge ending that cycle).
- `leds` lags the PWM counter and brightness computation by 1 cycle (registered).
- From `en` rising in IDLE with `period`=P, the first `step` occurs P cycles after entering RUN.
- Head duty at N=8, PWM_W=4: 15/16. Trail duties: 7, 3, 1 (/16).

## Structure
- Shared package `knight_rider_pkg` holds:
  - Mode constants `KR_MODE_BOUNCE`, `KR_MODE_WRAPL`, `KR_MODE_WRAPR`.
  - FSM state encoding.
  - The brightness function (level for trail age k).
- One sub-module `kr_pwm_channel`: takes the shared PWM counter and PWM_W-bit duty, outputs the registered LED bit. It is instantiated N_LEDS times via generate.
- Prescaler, FSM, motion and history live in the top.

## Test plan
- Reset behaviour: N=8, period=4, en=1 from reset release → `leds`=0 while `rst`=1. First `step` 4 cycles after RUN entry, `pos` 0→1.
- Bounce sweep: bounce, period=1 → `pos` sequence 0,1,…,7,6,…,0,1. `dir` falls on the step 7→6 and rises on the step 0→1. Period is 14 steps.
- Wrap modes: wrap-left at `pos`=7 → 0. Wrap-right at `pos`=0 → 7 with `dir`=0. Switching to bounce mid-sweep continues from that `pos`.
- Trail/PWM: period=64, `pos`=3 after moving left from 0. Over one 16-cycle PWM window, LED3 is high 15 cycles, LED2 7, LED1 3, LED0 1, all others 0. At a bounce reversal on `pos`=6, LED6 stays 15/16.
- Hold and period edge: drop `en` with the prescaler at 2 of period=10, hold 50 cycles → no `step`, `leds` keep pattern. On re-enable, `step` follows 8 cycles later. `period`=0 → `step` every RUN cycle. Lowering period 100→5 while the count is 40 → `step` next cycle.
- Async reset mid-operation: assert `rst` between clock edges at `pos`=5 → all outputs return to reset values immediately. After release and `en`=1, restart from `pos`=0 with no trail.

Source files
------------

// File: rtl/knight_rider_pkg.sv
// Shared types, mode constants and brightness helpers for the Knight Rider LED sequencer.
package knight_rider_pkg;

    typedef logic [1:0] kr_mode_t;

    localparam kr_mode_t KR_MODE_BOUNCE = 2'd0;
    localparam kr_mode_t KR_MODE_WRAPL  = 2'd1;
    localparam kr_mode_t KR_MODE_WRAPR  = 2'd2;

    typedef enum logic [1:0] {
        KR_IDLE = 2'd0,
        KR_RUN  = 2'd1,
        KR_HOLD = 2'd2
    } kr_state_e;

    // Full-scale PWM duty for a pwm_w-bit counter.
    function automatic int unsigned kr_full_level(input int unsigned pwm_w);
        return (32'd1 << pwm_w) - 32'd1;
    endfunction

    // Duty of a trail entry of the given age (0 = newest).
    function automatic int unsigned kr_trail_level(input int unsigned pwm_w, input int unsigned age);
        return kr_full_level(pwm_w) >> (age + 32'd1);
    endfunction

endpackage

// File: rtl/knight_rider_seq_if.sv
// Control/status bundle between the sequencer and whatever drives it.
interface knight_rider_seq_if
    import knight_rider_pkg::*;
#(
    parameter int unsigned N_LEDS  = 8,
    parameter int unsigned PRESC_W = 32
) ();
    localparam int unsigned POS_W = $clog2(N_LEDS);

    logic               en;
    kr_mode_t           mode;
    logic [PRESC_W-1:0] period;
    logic [N_LEDS-1:0]  leds;
    logic [POS_W-1:0]   pos;
    logic               dir;
    logic               step;

    modport master (output en, mode, period, input leds, pos, dir, step);
    modport slave  (input en, mode, period, output leds, pos, dir, step);

endinterface

// File: rtl/kr_pwm_channel.sv
// One LED PWM output: registered compare of the shared counter against this LED's duty.
module kr_pwm_channel #(
    parameter int unsigned PWM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] cnt_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic             led_o
);

    logic led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) led_q <= 1'b0;
        else     led_q <= (cnt_i < duty_i);
    end

    assign led_o = led_q;

endmodule

// File: rtl/knight_rider_seq.sv
// Knight Rider LED sequencer: step prescaler, run/hold FSM, head motion, trail history and PWM fan-out.
module knight_rider_seq
    import knight_rider_pkg::*;
#(
    parameter int unsigned N_LEDS  = 8,
    parameter int unsigned PRESC_W = 32,
    parameter int unsigned PWM_W   = 4,
    parameter int unsigned TRAIL   = 3
) (
    input  logic               clk,
    input  logic               rst,
    knight_rider_seq_if.slave  bus
);

    localparam int unsigned       POS_W  = $clog2(N_LEDS);
    localparam int unsigned       HIST_D = (TRAIL > 0) ? TRAIL : 1;
    localparam logic [POS_W-1:0]  LAST   = POS_W'(N_LEDS - 1);
    localparam logic [PWM_W-1:0]  FULL   = PWM_W'(kr_full_level(PWM_W));

    kr_state_e          state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic [POS_W-1:0]   hist_pos_q [HIST_D];
    logic [POS_W-1:0]   hist_pos_d [HIST_D];
    logic [HIST_D-1:0]  hist_vld_q, hist_vld_d;
    logic [PRESC_W-1:0] limit;
    logic [PWM_W-1:0]   duty [N_LEDS];
    logic [N_LEDS-1:0]  led_bits;

    // A zero period behaves as one clock per step.
    assign limit = (bus.period == '0) ? '0 : bus.period - PRESC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= KR_IDLE;
            presc_q    <= '0;
            pos_q      <= '0;
            dir_q      <= 1'b1;
            step_q     <= 1'b0;
            pwm_cnt_q  <= '0;
            hist_vld_q <= '0;
            for (int unsigned k = 0; k < HIST_D; k++) hist_pos_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            pwm_cnt_q  <= pwm_cnt_q + PWM_W'(1);
            hist_vld_q <= hist_vld_d;
            for (int unsigned k = 0; k < HIST_D; k++) hist_pos_q[k] <= hist_pos_d[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        hist_vld_d = hist_vld_q;
        for (int unsigned k = 0; k < HIST_D; k++) hist_pos_d[k] = hist_pos_q[k];

        case (state_q)
            KR_IDLE: if (bus.en)  state_d = KR_RUN;
            KR_RUN:  if (!bus.en) state_d = KR_HOLD;
            KR_HOLD: if (bus.en)  state_d = KR_RUN;
            default:              state_d = KR_IDLE;
        endcase

        // Motion only advances while running and still enabled; HOLD keeps the count.
        if (state_q == KR_RUN && bus.en) begin
            if (presc_q >= limit) begin
                step_d        = 1'b1;
                presc_d       = '0;
                hist_pos_d[0] = pos_q;
                hist_vld_d[0] = 1'b1;
                for (int unsigned k = 1; k < HIST_D; k++) begin
                    hist_pos_d[k] = hist_pos_q[k-1];
                    hist_vld_d[k] = hist_vld_q[k-1];
                end
                case (bus.mode)
                    KR_MODE_WRAPL: begin
                        dir_d = 1'b1;
                        pos_d = (pos_q == LAST) ? '0 : pos_q + POS_W'(1);
                    end
                    KR_MODE_WRAPR: begin
                        dir_d = 1'b0;
                        pos_d = (pos_q == '0) ? LAST : pos_q - POS_W'(1);
                    end
                    default: begin
                        if (dir_q) begin
                            if (pos_q == LAST) begin
                                dir_d = 1'b0;
                                pos_d = LAST - POS_W'(1);
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b1;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
                endcase
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Per-LED duty: brightest of head and matching trail entries; dark while idle.
    always_comb begin
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            duty[i] = '0;
            if (state_q != KR_IDLE) begin
                for (int unsigned k = 0; k < TRAIL; k++) begin
                    if (hist_vld_q[k] && hist_pos_q[k] == POS_W'(i)
                        && PWM_W'(kr_trail_level(PWM_W, k)) > duty[i]) begin
                        duty[i] = PWM_W'(kr_trail_level(PWM_W, k));
                    end
                end
                if (pos_q == POS_W'(i)) duty[i] = FULL;
            end
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_led
        kr_pwm_channel #(.PWM_W(PWM_W)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .cnt_i  (pwm_cnt_q),
            .duty_i (duty[i]),
            .led_o  (led_bits[i])
        );
    end

    assign bus.leds = led_bits;
    assign bus.pos  = pos_q;
    assign bus.dir  = dir_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_knight_rider_seq.sv
// Directed + randomized bench for knight_rider_seq against a cycle-level behavioural model.
module tb_knight_rider_seq;
    import knight_rider_pkg::*;

    localparam int unsigned N       = 8;
    localparam int unsigned PRESC_W = 32;
    localparam int unsigned PWM_W   = 4;
    localparam int unsigned TRAIL   = 3;
    localparam int          FULL    = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knight_rider_seq_if #(.N_LEDS(N), .PRESC_W(PRESC_W)) bus ();

    knight_rider_seq #(.N_LEDS(N), .PRESC_W(PRESC_W), .PWM_W(PWM_W), .TRAIL(TRAIL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: started = left reset with en seen; running = started and en at the last edge.
    bit           m_started, m_en_q, m_step;
    int           m_cnt, m_pos, m_dir, m_pwm;
    int           m_hist[$];
    logic [N-1:0] m_leds;

    int n, steps;
    int cnt[N];
    int exp_trail[N] = '{1, 3, 7, 15, 0, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int duty_of(input int i);
        int d = 0;
        for (int k = 0; k < m_hist.size(); k++)
            if (m_hist[k] == i && (FULL >> (k + 1)) > d) d = FULL >> (k + 1);
        if (i == m_pos) d = FULL;
        return d;
    endfunction

    task automatic model_reset();
        m_started = 0; m_en_q = 0; m_step = 0;
        m_cnt = 0; m_pos = 0; m_dir = 1; m_pwm = 0;
        m_leds = '0;
        m_hist.delete();
    endtask

    task automatic model_move();
        int nxt;
        case (int'(bus.mode))
            1: begin m_pos = (m_pos + 1) % N; m_dir = 1; end
            2: begin m_pos = (m_pos + N - 1) % N; m_dir = 0; end
            default: begin
                nxt = m_pos + (m_dir ? 1 : -1);
                if (nxt < 0 || nxt >= N) begin
                    m_dir = !m_dir;
                    nxt = m_pos + (m_dir ? 1 : -1);
                end
                m_pos = nxt;
            end
        endcase
    endtask

    task automatic model_edge();
        logic [N-1:0] nl;
        int per;
        for (int i = 0; i < N; i++) nl[i] = m_started && (m_pwm < duty_of(i));
        m_pwm  = (m_pwm + 1) % (1 << PWM_W);
        m_step = 0;
        if (m_started && m_en_q && bus.en) begin
            per = (bus.period == 0) ? 1 : int'(bus.period);
            if (m_cnt >= per - 1) begin
                m_step = 1;
                m_cnt  = 0;
                m_hist.push_front(m_pos);
                if (m_hist.size() > TRAIL) void'(m_hist.pop_back());
                model_move();
            end else begin
                m_cnt++;
            end
        end
        if (bus.en) m_started = 1;
        m_en_q = bus.en;
        m_leds = nl;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        chk("pos",  32'(bus.pos),  32'(m_pos));
        chk("dir",  32'(bus.dir),  32'(m_dir));
        chk("step", 32'(bus.step), 32'(m_step));
        chk("leds", 32'(bus.leds), 32'(m_leds));
    endtask

    task automatic wait_step(input int max, output int cycles);
        cycles = 0;
        do begin tick(); cycles++; end while (bus.step !== 1'b1 && cycles < max);
    endtask

    task automatic window16();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int w = 0; w < 16; w++) begin
            tick();
            for (int i = 0; i < N; i++) cnt[i] += int'(bus.leds[i]);
        end
    endtask

    initial begin
        // Reset and first-step latency.
        rst = 1'b1; bus.en = 1'b1; bus.mode = KR_MODE_BOUNCE; bus.period = 4;
        model_reset();
        repeat (3) tick();
        chk("rst_leds", 32'(bus.leds), 0);
        rst = 1'b0;
        wait_step(20, n);
        chk("first_step_lat", n, 5);
        chk("first_step_pos", 32'(bus.pos), 1);

        // Bounce sweep at one step per clock.
        bus.period = 1;
        repeat (40) tick();

        // Wrap-left 7 -> 0.
        bus.mode = KR_MODE_WRAPL;
        n = 0;
        while (bus.pos != 3'd7 && n < 16) begin tick(); n++; end
        chk("wrapl_reach7", 32'(n < 16), 1);
        tick();
        chk("wrapl_7to0", 32'(bus.pos), 0);

        // Wrap-right 0 -> 7, then resume bouncing from there.
        bus.mode = KR_MODE_WRAPR;
        n = 0;
        while (bus.pos != 3'd0 && n < 16) begin tick(); n++; end
        chk("wrapr_reach0", 32'(n < 16), 1);
        tick();
        chk("wrapr_0to7", 32'(bus.pos), 7);
        chk("wrapr_dir", 32'(bus.dir), 0);
        bus.mode = KR_MODE_BOUNCE;
        tick();
        chk("bounce_resume", 32'(bus.pos), 6);

        // Randomized mode/period/enable traffic.
        for (int r = 0; r < 300; r++) begin
            if (r % 7 == 0) bus.mode = 2'($urandom_range(0, 3));
            bus.period = PRESC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) bus.en = ~bus.en;
            tick();
        end
        bus.en = 1'b1;

        // Trail duties after moving 0 -> 3.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.mode = KR_MODE_BOUNCE; bus.period = 64;
        n = 0;
        while (bus.pos != 3'd3 && n < 400) begin tick(); n++; end
        chk("trail_reach3", 32'(n < 400), 1);
        tick();
        window16();
        for (int i = 0; i < N; i++) chk($sformatf("trail_led%0d", i), cnt[i], exp_trail[i]);

        // Head overrides its own trail on reversal 7 -> 6.
        n = 0;
        while (!(bus.step && bus.pos == 3'd6 && !bus.dir) && n < 1000) begin tick(); n++; end
        chk("rev_reach6", 32'(n < 1000), 1);
        tick();
        window16();
        chk("rev_led6", cnt[6], 15);
        chk("rev_led7", cnt[7], 7);
        chk("rev_led5", cnt[5], 1);

        // Hold with the prescaler at 2 of period 10.
        bus.period = 10;
        wait_step(20, n);
        chk("hold_sync", 32'(bus.step), 1);
        tick(); tick();
        bus.en = 1'b0;
        steps = 0;
        repeat (50) begin tick(); steps += int'(bus.step); end
        chk("hold_nostep", steps, 0);
        bus.en = 1'b1;
        wait_step(20, n);
        chk("resume_lat", n, 9);

        // Period zero steps every running cycle.
        bus.period = 0;
        steps = 0;
        repeat (10) begin tick(); steps += int'(bus.step); end
        chk("period0_steps", steps, 10);

        // Lowering the period below the current count steps next cycle.
        bus.period = 100;
        repeat (40) tick();
        chk("p100_nostep", 32'(bus.step), 0);
        bus.period = 5;
        tick();
        chk("lower_period_step", 32'(bus.step), 1);

        // Asynchronous reset between edges.
        bus.period = 1;
        n = 0;
        while (bus.pos != 3'd5 && n < 20) begin tick(); n++; end
        chk("async_reach5", 32'(n < 20), 1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_leds", 32'(bus.leds), 0);
        chk("async_pos",  32'(bus.pos),  0);
        chk("async_dir",  32'(bus.dir),  1);
        chk("async_step", 32'(bus.step), 0);
        tick();
        rst = 1'b0;
        bus.period = 2;
        wait_step(20, n);
        chk("restart_pos", 32'(bus.pos), 1);
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
